// File: rtl/bidir_bus.sv
// WIDTH-bit bidirectional pin port with sequenced turnaround and request/response handshake.
// Optional BIDIR_BUS_SYNC_EN adds a two-flop input synchronizer and extends SAMPLE by 2 cycles.
module bidir_bus #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DRIVE_CYCLES  = 1,
    parameter int unsigned SAMPLE_CYCLES = 2,
    parameter int unsigned TURN_CYCLES   = 1
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [WIDTH-1:0] PIN,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             oe,
    output logic             busy
);

`ifdef BIDIR_BUS_SYNC_EN
    localparam int unsigned SYNC_EXTRA = 2;
`else
    localparam int unsigned SYNC_EXTRA = 0;
`endif
    localparam int unsigned SAMP_LEN = SAMPLE_CYCLES + SYNC_EXTRA;
    localparam int unsigned MAX_DS   = (DRIVE_CYCLES > SAMP_LEN) ? DRIVE_CYCLES : SAMP_LEN;
    localparam int unsigned MAX_ALL  = (MAX_DS > TURN_CYCLES) ? MAX_DS : TURN_CYCLES;
    localparam int unsigned CW       = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

    typedef enum logic [1:0] {IDLE, TURN, DRIVE, SAMPLE} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              op_wr;
    logic              last_dir;
    logic [WIDTH-1:0]  dout;
    logic [WIDTH-1:0]  pin_in;
    logic [WIDTH-1:0]  cap_src;
    logic              accept;
    logic              leave_sample;
    logic              leave_drive;

    assign PIN       = oe ? dout : {WIDTH{1'bz}};
    assign pin_in    = PIN;
    assign req_ready = (state == IDLE) & ~reset;
    assign busy      = (state != IDLE);
    assign accept    = req_valid & req_ready;

`ifdef BIDIR_BUS_SYNC_EN
    logic [WIDTH-1:0] sync1, sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pin_in;
            sync2 <= sync1;
        end
    end

    assign cap_src = sync2;
`else
    assign cap_src = pin_in;
`endif

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        leave_sample = 1'b0;
        leave_drive  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if ((req_write != last_dir) && (TURN_CYCLES != 0)) begin
                        state_n = TURN;
                        cnt_n   = CW'(TURN_CYCLES - 1);
                    end else if (req_write) begin
                        state_n = DRIVE;
                        cnt_n   = CW'(DRIVE_CYCLES - 1);
                    end else begin
                        state_n = SAMPLE;
                        cnt_n   = CW'(SAMP_LEN - 1);
                    end
                end
            end
            TURN: begin
                if (cnt == '0) begin
                    if (op_wr) begin
                        state_n = DRIVE;
                        cnt_n   = CW'(DRIVE_CYCLES - 1);
                    end else begin
                        state_n = SAMPLE;
                        cnt_n   = CW'(SAMP_LEN - 1);
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    state_n     = IDLE;
                    leave_drive = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            SAMPLE: begin
                if (cnt == '0) begin
                    state_n      = IDLE;
                    leave_sample = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // oe is registered and parks high after a write until a read releases the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op_wr     <= 1'b0;
            last_dir  <= 1'b0;
            dout      <= '0;
            oe        <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rsp_valid <= leave_sample;
            if (accept) begin
                op_wr <= req_write;
                dout  <= req_data;
            end
            if (state_n == DRIVE)
                oe <= 1'b1;
            else if ((state_n == TURN) || (state_n == SAMPLE))
                oe <= 1'b0;
            if (leave_drive)
                last_dir <= 1'b1;
            if (leave_sample) begin
                last_dir <= 1'b0;
                rsp_data <= cap_src;
            end
        end
    end

endmodule

// File: tb/tb_bidir_bus.sv
// Directed self-checking bench for bidir_bus with default parameters.
// Honours BIDIR_BUS_SYNC_EN by extending the expected read latency by 2.
module tb_bidir_bus;

`ifdef BIDIR_BUS_SYNC_EN
    localparam int SEXTRA = 2;
`else
    localparam int SEXTRA = 0;
`endif
    localparam int S = 2 + SEXTRA;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    wire  [7:0] PIN;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [7:0] req_data = '0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       oe;
    logic       busy;
    logic       tb_drv = 1'b0;
    logic [7:0] tb_val = '0;

    int checks = 0;
    int errors = 0;

    assign PIN = tb_drv ? tb_val : 8'bzzzzzzzz;

    always #5 clk = ~clk;

    bidir_bus #(
        .WIDTH(8),
        .DRIVE_CYCLES(1),
        .SAMPLE_CYCLES(2),
        .TURN_CYCLES(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .PIN(PIN),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_data(req_data),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .oe(oe),
        .busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", oe); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %h want 00", rsp_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", req_ready); end
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", req_ready); end
    endtask

    task automatic test_first_write;
        req_valid = 1'b1; req_write = 1'b1; req_data = 8'hA5;
        tick();
        req_valid = 1'b0;
        checks++; if (oe !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wr1_turn oe=%b busy=%b want oe=0 busy=1", oe, busy); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL wr1_turn_ready got %b want 0", req_ready); end
        tick();
        checks++; if (oe !== 1'b1 || PIN !== 8'hA5) begin errors++; $display("FAIL wr1_drive oe=%b pin=%h want 1/a5", oe, PIN); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL wr1_drive_ready got %b want 0", req_ready); end
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wr1_done_ready got %b want 1", req_ready); end
        tick();
        checks++; if (oe !== 1'b1 || PIN !== 8'hA5) begin errors++; $display("FAIL wr1_park oe=%b pin=%h want 1/a5", oe, PIN); end
    endtask

    task automatic test_write_read;
        req_valid = 1'b1; req_write = 1'b1; req_data = 8'h3C;
        tick();
        req_valid = 1'b0;
        checks++; if (oe !== 1'b1 || PIN !== 8'h3C) begin errors++; $display("FAIL wr2_noturn oe=%b pin=%h want 1/3c", oe, PIN); end
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wr2_done_ready got %b want 1", req_ready); end
        req_valid = 1'b1; req_write = 1'b0; req_data = 8'hFF;
        tick();
        req_valid = 1'b0;
        checks++; if (oe !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rd_turn oe=%b busy=%b want 0/1", oe, busy); end
        tb_val = 8'h5A; tb_drv = 1'b1;
        for (int i = 1; i <= 1 + S; i++) begin
            tick();
            checks++;
            if (oe !== 1'b0) begin errors++; $display("FAIL rd_contention step %0d oe=%b want 0", i, oe); end
            checks++;
            if (rsp_valid !== (i == 1 + S)) begin errors++; $display("FAIL rd_valid_timing step %0d got %b want %b", i, rsp_valid, (i == 1 + S)); end
        end
        checks++; if (rsp_data !== 8'h5A) begin errors++; $display("FAIL rd_data got %h want 5a", rsp_data); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 8'h5A) begin errors++; $display("FAIL rd_pulse_hold valid=%b data=%h want 0/5a", rsp_valid, rsp_data); end
    endtask

    task automatic test_back_to_back;
        tb_val = 8'h11;
        req_valid = 1'b1; req_write = 1'b0;
        tick();
        checks++; if (req_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_acc1 ready=%b busy=%b want 0/1", req_ready, busy); end
        for (int i = 1; i <= S; i++) begin
            tick();
            checks++;
            if (rsp_valid !== (i == S)) begin errors++; $display("FAIL b2b_valid1 step %0d got %b want %b", i, rsp_valid, (i == S)); end
        end
        checks++; if (rsp_data !== 8'h11 || req_ready !== 1'b1) begin errors++; $display("FAIL b2b_data1 data=%h ready=%b want 11/1", rsp_data, req_ready); end
        tb_val = 8'h22;
        tick();
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_acc2 busy=%b valid=%b want 1/0", busy, rsp_valid); end
        for (int i = 1; i <= S; i++) begin
            tick();
            checks++;
            if (rsp_valid !== (i == S)) begin errors++; $display("FAIL b2b_valid2 step %0d got %b want %b", i, rsp_valid, (i == S)); end
        end
        checks++; if (rsp_data !== 8'h22) begin errors++; $display("FAIL b2b_data2 got %h want 22", rsp_data); end
        tb_drv = 1'b0;
        tick();
    endtask

    task automatic test_hold_valid;
        logic [7:0] exp_rdy;
        exp_rdy = 8'hA9;
        req_valid = 1'b1; req_write = 1'b1; req_data = 8'h77;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (req_ready !== exp_rdy[k]) begin errors++; $display("FAIL hold_ready step %0d got %b want %b", k, req_ready, exp_rdy[k]); end
            tick();
        end
        req_valid = 1'b0;
        tick();
        checks++; if (req_ready !== 1'b1 || oe !== 1'b1 || PIN !== 8'h77) begin errors++; $display("FAIL hold_end ready=%b oe=%b pin=%h want 1/1/77", req_ready, oe, PIN); end
    endtask

    task automatic test_reset_mid_sample;
        req_valid = 1'b1; req_write = 1'b0;
        tick();
        req_valid = 1'b0;
        tb_val = 8'h99; tb_drv = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++; if (oe !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out oe=%b valid=%b want 0/0", oe, rsp_valid); end
        checks++; if (busy !== 1'b0 || rsp_data !== 8'h00) begin errors++; $display("FAIL rstmid_state busy=%b data=%h want 0/00", busy, rsp_data); end
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", req_ready); end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_rsp step %0d got %b want 0", i, rsp_valid); end
        end
        tb_drv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_write();
        test_write_read();
        test_back_to_back();
        test_hold_valid();
        test_reset_mid_sample();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
